// File: rtl/seq_password_checker.sv
// Serial password checker: user password from external memory, admin password fixed.
// Define SPC_LOCK_TIMEOUT_EN to leave LOCKED automatically after LOCK_CYCLES cycles.
module seq_password_checker #(
  parameter int DIGITS = 4,
  parameter int DIGIT_W = 4,
  parameter int MAX_ERR = 3,
  parameter logic [DIGITS*DIGIT_W-1:0] ADMIN_PW = '0,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       digit_valid,
  input  logic [DIGIT_W-1:0]         digit,
  input  logic                       clear,
  input  logic                       relock,
  output logic [$clog2(DIGITS)-1:0]  mem_addr,
  input  logic [DIGIT_W-1:0]         mem_data,
  output logic                       unlock,
  output logic                       locked,
  output logic                       error,
  output logic                       admin_ok,
  output logic [$clog2(MAX_ERR+1)-1:0] err_count,
  output logic [$clog2(DIGITS)-1:0]  entry_idx
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int ERR_W = $clog2(MAX_ERR + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(MAX_ERR);

  if (DIGITS < 2 || MAX_ERR < 1 || LOCK_CYCLES < 1) begin : g_bad_cfg
    $error("seq_password_checker: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_ENTRY    = 2'd0,
    S_UNLOCKED = 2'd1,
    S_LOCKED   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               um_q, um_d;
  logic               am_q, am_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               error_q, error_d;
  logic               admin_ok_q, admin_ok_d;
  logic               unlock_q, unlock_d;
  logic               locked_q, locked_d;

  logic [DIGIT_W-1:0] admin_dig;
  logic               um_n;
  logic               am_n;

`ifdef SPC_LOCK_TIMEOUT_EN
  localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [TW-1:0] T_LOAD = TW'(LOCK_CYCLES - 1);
  logic [TW-1:0] timer_q, timer_d;
`endif

  assign admin_dig = DIGIT_W'(ADMIN_PW >> (DIGIT_W * int'(idx_q)));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    um_d       = um_q;
    am_d       = am_q;
    err_d      = err_q;
    error_d    = 1'b0;
    admin_ok_d = 1'b0;
    um_n       = um_q && (digit == mem_data);
    am_n       = am_q && (digit == admin_dig);
    unique case (state_q)
      S_UNLOCKED: begin
        if (relock) begin
          state_d = S_ENTRY;
          idx_d   = '0;
          um_d    = 1'b1;
          am_d    = 1'b1;
        end
      end
      default: begin
        if (clear) begin
          idx_d = '0;
          um_d  = 1'b1;
          am_d  = 1'b1;
        end else if (digit_valid && idx_q != LAST) begin
          idx_d = idx_q + 1'b1;
          um_d  = um_n;
          am_d  = am_n;
        end else if (digit_valid) begin
          idx_d = '0;
          um_d  = 1'b1;
          am_d  = 1'b1;
          // Whole entry resolved at once; LOCKED never honours the user password.
          if (state_q == S_ENTRY && um_n) begin
            state_d = S_UNLOCKED;
            err_d   = '0;
          end else if (am_n) begin
            state_d    = S_ENTRY;
            admin_ok_d = 1'b1;
            err_d      = '0;
          end else if (state_q == S_ENTRY) begin
            error_d = 1'b1;
            err_d   = err_q + 1'b1;
            if (err_d == ERR_MAX) state_d = S_LOCKED;
          end else begin
            error_d = 1'b1;
            err_d   = ERR_MAX;
          end
        end
      end
    endcase
`ifdef SPC_LOCK_TIMEOUT_EN
    timer_d = timer_q;
    if (state_q == S_LOCKED) begin
      if (timer_q == '0) begin
        state_d = S_ENTRY;
        err_d   = '0;
        idx_d   = '0;
        um_d    = 1'b1;
        am_d    = 1'b1;
        error_d = 1'b0;
      end else begin
        timer_d = timer_q - 1'b1;
      end
    end else if (state_d == S_LOCKED) begin
      timer_d = T_LOAD;
    end
`endif
    unlock_d = (state_d == S_UNLOCKED);
    locked_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_ENTRY;
      idx_q      <= '0;
      um_q       <= 1'b1;
      am_q       <= 1'b1;
      err_q      <= '0;
      error_q    <= 1'b0;
      admin_ok_q <= 1'b0;
      unlock_q   <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      um_q       <= um_d;
      am_q       <= am_d;
      err_q      <= err_d;
      error_q    <= error_d;
      admin_ok_q <= admin_ok_d;
      unlock_q   <= unlock_d;
      locked_q   <= locked_d;
    end
  end

`ifdef SPC_LOCK_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) timer_q <= '0;
    else      timer_q <= timer_d;
  end
`endif

  assign mem_addr  = idx_q;
  assign entry_idx = idx_q;
  assign err_count = err_q;
  assign error     = error_q;
  assign admin_ok  = admin_ok_q;
  assign unlock    = unlock_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_seq_password_checker.sv
// Directed bench for seq_password_checker: stored 1-2-3-4, admin 5-5-5-5.
module tb_seq_password_checker;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = '0;
  logic       clear = 1'b0;
  logic       relock = 1'b0;
  logic [1:0] mem_addr;
  logic [3:0] mem_data;
  logic       unlock, locked, error, admin_ok;
  logic [1:0] err_count;
  logic [1:0] entry_idx;

  logic [3:0] stored [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  assign mem_data = stored[mem_addr];

  seq_password_checker #(
    .DIGITS(4), .DIGIT_W(4), .MAX_ERR(3),
    .ADMIN_PW(16'h5555), .LOCK_CYCLES(16)
  ) dut (
    .CLK(CLK), .RST(RST),
    .digit_valid(digit_valid), .digit(digit),
    .clear(clear), .relock(relock),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .unlock(unlock), .locked(locked),
    .error(error), .admin_ok(admin_ok),
    .err_count(err_count), .entry_idx(entry_idx)
  );

  typedef struct {
    logic       clr;
    logic       dv;
    logic [3:0] dig;
    logic       rl;
    logic [7:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic logic [7:0] pk(logic u, logic l, logic e,
                                    logic a, logic [1:0] ec,
                                    logic [1:0] ix);
    return {u, l, e, a, ec, ix};
  endfunction

  function automatic logic [7:0] outs();
    return {unlock, locked, error, admin_ok, err_count, entry_idx};
  endfunction

  task automatic add(logic c, logic v, logic [3:0] d, logic r,
                     logic [7:0] e);
    vec_t t;
    t.clr = c; t.dv = v; t.dig = d; t.rl = r; t.exp = e;
    vq.push_back(t);
  endtask

  // Four digits; first three keep the prior levels, last gets fin.
  task automatic ent(logic [3:0] a, logic [3:0] b, logic [3:0] c,
                     logic [3:0] d, logic u0, logic l0,
                     logic [1:0] ec0, logic [7:0] fin);
    add(0, 1, a, 0, pk(u0, l0, 0, 0, ec0, 2'd1));
    add(0, 1, b, 0, pk(u0, l0, 0, 0, ec0, 2'd2));
    add(0, 1, c, 0, pk(u0, l0, 0, 0, ec0, 2'd3));
    add(0, 1, d, 0, fin);
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  task automatic step(logic c, logic v, logic [3:0] d, logic r);
    @(negedge CLK);
    clear = c; digit_valid = v; digit = d; relock = r;
    @(posedge CLK);
    #1;
    clear = 0; digit_valid = 0; digit = '0; relock = 0;
  endtask

  task automatic hand_ent(logic [3:0] a, logic [3:0] b,
                          logic [3:0] c, logic [3:0] d);
    step(0, 1, a, 0);
    step(0, 1, b, 0);
    step(0, 1, c, 0);
    step(0, 1, d, 0);
  endtask

  initial begin
    int fall_at;
    stored[0] = 4'd1; stored[1] = 4'd2;
    stored[2] = 4'd3; stored[3] = 4'd4;

    ent(1, 2, 3, 4, 0, 0, 0, pk(1, 0, 0, 0, 0, 0));
    add(0, 0, 0, 1, pk(0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 1, pk(0, 0, 0, 0, 0, 0));
    ent(1, 9, 3, 4, 0, 0, 0, pk(0, 0, 1, 0, 1, 0));
    ent(1, 9, 3, 4, 0, 0, 1, pk(0, 0, 1, 0, 2, 0));
    ent(1, 9, 3, 4, 0, 0, 2, pk(0, 1, 1, 0, 3, 0));
    ent(1, 2, 3, 4, 0, 1, 3, pk(0, 1, 1, 0, 3, 0));
    add(0, 0, 0, 1, pk(0, 1, 0, 0, 3, 0));
    add(0, 0, 0, 0, pk(0, 1, 0, 0, 3, 0));
    ent(5, 5, 5, 5, 0, 1, 3, pk(0, 0, 0, 1, 0, 0));
    ent(1, 2, 3, 4, 0, 0, 0, pk(1, 0, 0, 0, 0, 0));
    add(0, 1, 7, 0, pk(1, 0, 0, 0, 0, 0));
    add(1, 0, 0, 0, pk(1, 0, 0, 0, 0, 0));
    add(0, 0, 0, 1, pk(0, 0, 0, 0, 0, 0));
    add(0, 1, 1, 0, pk(0, 0, 0, 0, 0, 1));
    add(0, 1, 2, 0, pk(0, 0, 0, 0, 0, 2));
    add(1, 1, 3, 0, pk(0, 0, 0, 0, 0, 0));
    ent(1, 2, 3, 4, 0, 0, 0, pk(1, 0, 0, 0, 0, 0));
    add(0, 0, 0, 1, pk(0, 0, 0, 0, 0, 0));
    ent(5, 5, 5, 5, 0, 0, 0, pk(0, 0, 0, 1, 0, 0));
    ent(1, 2, 3, 5, 0, 0, 0, pk(0, 0, 1, 0, 1, 0));
    add(0, 1, 1, 0, pk(0, 0, 0, 0, 1, 1));
    add(1, 0, 0, 0, pk(0, 0, 0, 0, 1, 0));
    ent(1, 2, 3, 4, 0, 0, 1, pk(1, 0, 0, 0, 0, 0));
    add(0, 0, 0, 1, pk(0, 0, 0, 0, 0, 0));

    #12;
    chk("reset_outs", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 0)));
    chk("reset_addr", 32'(mem_addr), 0);
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].clr, vq[i].dv, vq[i].dig, vq[i].rl);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vq[i].exp));
    end

    hand_ent(1, 9, 3, 4);
    hand_ent(1, 9, 3, 4);
    chk("pre_rst_err", 32'(err_count), 2);
    step(0, 1, 1, 0);
    step(0, 1, 2, 0);
    chk("pre_rst_idx", 32'(entry_idx), 2);
    RST = 1'b0;
    #1;
    chk("async_rst", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 0)));
    @(negedge CLK);
    RST = 1'b1;
    hand_ent(1, 2, 3, 4);
    chk("post_rst_unlock", 32'(outs()), 32'(pk(1, 0, 0, 0, 0, 0)));
    step(0, 0, 0, 1);

`ifdef SPC_LOCK_TIMEOUT_EN
    hand_ent(1, 9, 3, 4);
    hand_ent(1, 9, 3, 4);
    hand_ent(1, 9, 3, 4);
    chk("to_locked", 32'(locked), 1);
    fall_at = -1;
    for (int c = 1; c <= 40 && fall_at < 0; c++) begin
      @(posedge CLK);
      #1;
      if (!locked) fall_at = c;
    end
    chk("to_cycles", 32'(fall_at), 16);
    chk("to_err", 32'(err_count), 0);
    hand_ent(1, 2, 3, 4);
    chk("to_unlock", 32'(unlock), 1);
`else
    fall_at = 0;
    chk("idle_state", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, fall_at[1:0])));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_password_checker.md
# seq_password_checker

Parametrised serial password checker for the password lock. Accepts one digit per `digit_valid` strobe, compares the full entry against a stored user password (read digit-by-digit from external memory) and a compile-time admin password, and drives unlock, error and lockdown status. Improves on the fixed 4-digit validator with configurable length, digit width and attempt limit; whole-entry evaluation (no early reveal of the wrong position); an abort input; and an optional timed lockout.

## Interface
- `DIGITS`, 4: password length, ≥2
- `DIGIT_W`, 4: bits per digit
- `MAX_ERR`, 3: consecutive failed entries that trigger lockdown, ≥1
- `ADMIN_PW`, 0: admin password, `DIGITS*DIGIT_W` bits; digit 0 in LSBs
- `LOCK_CYCLES`, 1024: lockout duration; used only with `SPC_LOCK_TIMEOUT_EN`, ≥1
- `CLK`  in  1  clock
- `RST`  in  1  reset, asynchronous, active-low
- `digit_valid`  in  1  one digit presented this cycle
- `digit`  in  DIGIT_W  user digit
- `clear`  in  1  abort partial entry; not counted as an error
- `relock`  in  1  leave UNLOCKED, return to ENTRY
- `mem_addr`  out  clog2(DIGITS)  index of stored digit to compare
- `mem_data`  in  DIGIT_W  stored user digit at `mem_addr`; combinational, same cycle
- `unlock`  out  1  level, high in UNLOCKED
- `locked`  out  1  level, high in LOCKED
- `error`  out  1  one-cycle pulse on a failed entry
- `admin_ok`  out  1  one-cycle pulse on an admin-password entry
- `err_count`  out  clog2(MAX_ERR+1)  consecutive failures
- `entry_idx`  out  clog2(DIGITS)  digits accepted in the current entry

## Operation
- States: ENTRY, UNLOCKED, LOCKED. Reset → ENTRY with idx=0, both match flags=1, `err_count`=0, and `unlock`/`locked`/`error`/`admin_ok`=0.
- `mem_addr` = idx in every state.
- On an accepted digit in ENTRY or LOCKED:
  - `user_match &= (digit == mem_data)`
  - `admin_match &= (digit == ADMIN_PW[idx])`
  - idx++
- Nothing is reported until digit `DIGITS-1`. On that digit, idx→0, both flags→1, and the result is resolved in priority order:
  1. ENTRY and user match → UNLOCKED; `err_count`→0.
  2. Admin match, in any state → ENTRY; `admin_ok` pulse; `err_count`→0; clears lockdown.
  3. ENTRY with neither match → `error` pulse; `err_count`++. If the new count equals MAX_ERR → LOCKED.
  4. LOCKED with no admin match → stays LOCKED; `error` pulse; `err_count` saturates at MAX_ERR.
- In LOCKED a user-password match is ignored. Only an admin entry (or the timeout) leaves LOCKED.
- UNLOCKED ignores digits and `clear`. `relock` → ENTRY with idx=0; `err_count` unchanged (already 0).
- `clear` in ENTRY/LOCKED: idx→0, flags→1, no error, state unchanged.
- `clear` and `digit_valid` in the same cycle: `clear` wins and the digit is dropped.
- `relock` outside UNLOCKED: ignored.

## Timing
- All outputs are registered.
- `unlock`/`locked`/`error`/`admin_ok` update in the cycle after the final digit's accepting edge.
- `entry_idx` updates in the cycle after each accepted digit.
- Back-to-back digits are allowed on every cycle. A new entry may begin in the cycle right after the final digit.
- `mem_data` is sampled on the same edge as `digit`. No read latency is tolerated.
- Async reset mid-entry discards the partial entry and restores all reset values immediately.

## Configuration
- `SPC_LOCK_TIMEOUT_EN` defined:
  - Entering LOCKED loads a down-counter with LOCK_CYCLES−1.
  - At 0 → ENTRY, `err_count`→0, partial entry discarded.
  - If expiry coincides with a final admin digit: result ENTRY, `admin_ok` still pulses.
- Undefined: no counter logic; LOCKED is left only by admin entry.

## Test plan
- DIGITS=4, stored 1-2-3-4; enter 1,2,3,4 on consecutive cycles → `unlock`=1 the cycle after the 4th digit; `err_count`=0.
- Enter 1,9,3,4 → no output until the 4th digit, then one `error` pulse, `err_count`=1, `unlock`=0. Repeat twice more → `locked`=1, `err_count`=3.
- While LOCKED, enter correct user 1-2-3-4 → `error` pulse, remains LOCKED. Enter ADMIN_PW=5-5-5-5 → `admin_ok` pulse, `locked`=0, `err_count`=0, next 1-2-3-4 unlocks.
- Enter 1,2, then `clear` together with `digit_valid`(3), then 1,2,3,4 → `entry_idx` 0 after clear, unlock, no error.
- Assert `RST` low after 2 digits with `err_count`=2 → all outputs 0 immediately; 1-2-3-4 then unlocks.
- With `SPC_LOCK_TIMEOUT_EN`, LOCK_CYCLES=16: trigger LOCKED, idle → `locked` falls exactly 16 cycles after it rose; `err_count`=0.
